// File: rtl/skew_decoder.sv
// skew_decoder: turns one BRAM row per channel per handshake into a diagonal
// wavefront for the left edge of a systolic array. Row r of a tile lands at
// lane offset r across 2*MATRIX_SIZE-1 lanes; all VECTOR channels move in
// lockstep.
// Optional feature macro: SKEW_DECODER_DRAIN_EN appends MATRIX_SIZE-1 zero
// beats after the last row so the wavefront fully traverses the array.
module skew_decoder #(
  parameter int REG_WIDTH   = 16,
  parameter int MATRIX_SIZE = 4,
  parameter int VECTOR      = 2
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         start,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic [VECTOR*MATRIX_SIZE*REG_WIDTH-1:0]      data_bram,
  output logic [VECTOR*(2*MATRIX_SIZE-1)*REG_WIDTH-1:0] lanes,
  output logic                                         out_valid,
  output logic                                         compute_start,
  output logic                                         busy,
  output logic                                         done
);

  localparam int ARRAY_SIZE = 2*MATRIX_SIZE-1;
  localparam int LANES_W    = VECTOR*ARRAY_SIZE*REG_WIDTH;
  localparam int CNT_W      = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(MATRIX_SIZE-1);

`ifdef SKEW_DECODER_DRAIN_EN
  localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'((MATRIX_SIZE > 1) ? MATRIX_SIZE-2 : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;
`else
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FEED = 1'b1
  } state_t;
`endif

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_row_cnt;
  logic [CNT_W-1:0]   w_row_cnt_next;
`ifdef SKEW_DECODER_DRAIN_EN
  logic [CNT_W-1:0]   r_drain_cnt;
  logic [CNT_W-1:0]   w_drain_cnt_next;
`endif

  logic               w_in_ready;
  logic               w_hs;
  logic               w_beat;
  logic               w_cs;
  logic               w_done;
  logic [LANES_W-1:0] w_lanes_next;

  logic [LANES_W-1:0] r_lanes;
  logic               r_out_valid;
  logic               r_compute_start;
  logic               r_done;

  // Next-state and per-cycle beat control for the IDLE/FEED/DRAIN sequencer
  always_comb begin
    w_state_next     = r_state;
    w_row_cnt_next   = r_row_cnt;
`ifdef SKEW_DECODER_DRAIN_EN
    w_drain_cnt_next = r_drain_cnt;
`endif
    w_in_ready       = 1'b0;
    w_hs             = 1'b0;
    w_beat           = 1'b0;
    w_cs             = 1'b0;
    w_done           = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next   = ST_FEED;
          w_row_cnt_next = '0;
        end
      end
      ST_FEED: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          w_hs           = 1'b1;
          w_beat         = 1'b1;
          w_cs           = (r_row_cnt == '0);
          w_row_cnt_next = r_row_cnt + 1'b1;
          if (r_row_cnt == LAST_ROW) begin
`ifdef SKEW_DECODER_DRAIN_EN
            if (MATRIX_SIZE > 1) begin
              w_state_next     = ST_DRAIN;
              w_drain_cnt_next = '0;
            end else begin
              w_state_next = ST_IDLE;
              w_done       = 1'b1;
            end
`else
            w_state_next = ST_IDLE;
            w_done       = 1'b1;
`endif
          end
        end
      end
`ifdef SKEW_DECODER_DRAIN_EN
      ST_DRAIN: begin
        // Zero beats keep the array clocking until the last row clears it
        w_beat           = 1'b1;
        w_drain_cnt_next = r_drain_cnt + 1'b1;
        if (r_drain_cnt == LAST_DRAIN) begin
          w_state_next = ST_IDLE;
          w_done       = 1'b1;
        end
      end
`endif
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Skew placement: element k of row r goes to lane k+r; bubbles and drain beats are zero
  always_comb begin
    w_lanes_next = '0;
    if (w_hs) begin
      for (int c = 0; c < VECTOR; c++) begin
        for (int j = 0; j < ARRAY_SIZE; j++) begin
          for (int k = 0; k < MATRIX_SIZE; k++) begin
            if (j == k + int'(r_row_cnt)) begin
              w_lanes_next[(c*ARRAY_SIZE+j)*REG_WIDTH +: REG_WIDTH] =
                data_bram[(c*MATRIX_SIZE+k)*REG_WIDTH +: REG_WIDTH];
            end
          end
        end
      end
    end
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_row_cnt   <= '0;
`ifdef SKEW_DECODER_DRAIN_EN
      r_drain_cnt <= '0;
`endif
    end else begin
      r_state     <= w_state_next;
      r_row_cnt   <= w_row_cnt_next;
`ifdef SKEW_DECODER_DRAIN_EN
      r_drain_cnt <= w_drain_cnt_next;
`endif
    end
  end

  // Output beat register: lanes and their strobes appear one cycle after acceptance
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lanes         <= '0;
      r_out_valid     <= 1'b0;
      r_compute_start <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_lanes         <= w_lanes_next;
      r_out_valid     <= w_beat;
      r_compute_start <= w_cs;
      r_done          <= w_done;
    end
  end

  assign lanes         = r_lanes;
  assign out_valid     = r_out_valid;
  assign compute_start = r_compute_start;
  assign done          = r_done;
  assign busy          = (r_state != ST_IDLE);
  assign in_ready      = w_in_ready;

endmodule

// File: doc/skew_decoder.md
# skew_decoder

Parametrised successor to the systolic-array input decoder. It accepts one BRAM row per channel per handshake, places row `r` of a tile at lane offset `r` across `2*MATRIX_SIZE-1` lanes to form the diagonal wavefront, and optionally appends zero drain beats. It sits between the BRAM read port and the left edge of the systolic array, and drives `VECTOR` independent channels in lockstep.

## Interface
Parameters:
- `REG_WIDTH`, 16, element width in bits.
- `MATRIX_SIZE`, 4, rows per tile and elements per row; legal range 1..16.
- `VECTOR`, 2, number of parallel channels.
- `ARRAY_SIZE`, derived localparam `2*MATRIX_SIZE-1`, lanes per channel.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  begins a tile; honoured only in IDLE.
- `in_valid`  in  1  `data_bram` holds a valid row.
- `in_ready`  out  1  block accepts a row this cycle.
- `data_bram`  in  `VECTOR*MATRIX_SIZE*REG_WIDTH`  channel `c` row at bits `[c*M*W +: M*W]`; element `k` at `[k*W +: W]` within the row.
- `lanes`  out  `VECTOR*ARRAY_SIZE*REG_WIDTH`  channel `c` lane `j` at `[(c*ARRAY_SIZE+j)*W +: W]`; registered.
- `out_valid`  out  1  `lanes` carries a beat.
- `compute_start`  out  1  one-cycle pulse on the first beat of a tile.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse on the last beat of a tile.

## Operation
- FSM states: IDLE, FEED, DRAIN.
- IDLE: `in_ready=0`. `start=1` moves to FEED and clears `row_cnt`.
- FEED: `in_ready=1`. A handshake (`in_valid & in_ready`) at row `r` loads `lanes`: lane `j` = element `j-r` when `r <= j < r+M`, else 0. The same rule applies to every channel.
- `row_cnt` increments on each handshake.
- A handshake with `row_cnt==M-1` leaves FEED: to DRAIN when drain is compiled in and `M>1`, otherwise to IDLE.
- A FEED cycle without `in_valid` produces a bubble on the next cycle: `out_valid=0` and `lanes` all zero. `row_cnt` holds.
- DRAIN: `in_ready=0`. Loads all-zero `lanes` with `out_valid=1` for `M-1` cycles, counted by `drain_cnt`, then returns to IDLE.
- `compute_start` is registered alongside the beat of row 0.
- `done` is registered alongside the final beat, either the last row or the last drain beat. The state register reads IDLE in that same cycle, so a `start` in the `done` cycle is accepted.
- `start` outside IDLE is ignored.
- No downstream backpressure; the array consumes every beat.

## Timing
- Reset values:
  - State IDLE; `row_cnt` and `drain_cnt` = 0.
  - `lanes` = 0.
  - `out_valid`, `compute_start`, `done`, `busy`, `in_ready` = 0.
- Latency: a row accepted in cycle `t` appears on `lanes` in cycle `t+1`.
- Tile duration with no bubbles, from `start` in cycle 0:
  - Rows are accepted in cycles 1..M.
  - Beats appear in cycles 2..M+1; drain beats in M+2..2M.
  - `done` is high in cycle 2M with drain, or M+1 without.
- `M=1`: a single beat carries both `compute_start` and `done`; DRAIN is never entered.
- Reset mid-tile takes effect on the next edge and returns to IDLE. No `done` is issued, and outputs return to reset values in the following cycle.
- Reset has priority over `start` and over any handshake.

## Configuration
- `SKEW_DECODER_DRAIN_EN`:
  - Defined: the DRAIN state and `drain_cnt` exist, and every tile ends with `M-1` zero beats so the wavefront fully traverses the array.
  - Undefined: there is no DRAIN state, and FEED returns directly to IDLE after row `M-1`. `done` then coincides with the last row beat, and the caller supplies any flush.

## Test plan
- Use `M=4`, `W=16`, `VECTOR=2`.
- Channel 0 row `r` element `k` = 0x0R0K; channel 1 row `r` element `k` = 0x1R0K.
- Scenarios:
  - Drain on, `start` in cycle 0, `in_valid` held high:
    - Beat at cycle 3: channel 0 lanes 1..4 = 0x0100..0x0103, lanes 0,5,6 = 0.
    - `compute_start` high at cycle 2.
    - Zero beats at cycles 6..8; `done` high at cycle 8.
  - Drain off, same stimulus: no zero beats, `done` high at cycle 5, and `busy` low from cycle 5.
  - `in_valid` low in cycle 2: bubble with `out_valid=0` at cycle 3; row 1 appears at cycle 4; `done` slips one cycle to cycle 9.
  - `start` pulsed during FEED: no effect. `start` in the `done` cycle: the next tile's row 0 is accepted the following cycle.
  - `reset` asserted in cycle 3: outputs are 0 and state is IDLE from cycle 4; no `done`; a new tile after reset completes normally.
  - `M=1` with drain on: one beat with lane 0 = element 0, and `compute_start` and `done` high in the same cycle.
